iod_read_training_tap_ctrl: RTL and testbench

- Fabric-side controller for one DDR4 read-training IOD lane.
- Drives the lane's dynamic delay line (load/move/direction) and eye-monitor flag clear.
- Consumes RX data, eye-monitor early/late flags and the out-of-range indication.
- Sweeps the input delay, finds the first contiguous passing window and parks the tap at the window centre. It reports the result to the training sequencer.

---
 rtl/iod_read_training_tap_ctrl_pkg.sv | 22 ++
 rtl/iod_read_training_tap_ctrl_if.sv | 38 +++
 rtl/iod_read_training_tap_ctrl_settle_timer.sv | 33 +++
 rtl/iod_read_training_tap_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_iod_read_training_tap_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iod_read_training_tap_ctrl_pkg.sv
// Shared types and constants for the DDR4 read-training tap controller.
package iod_training_pkg;

  localparam int TAP_W_DEFAULT = 7;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    EVAL,
    STEP,
    CENTER,
    FIN_OK,
    FIN_FAIL
  } tap_state_t;

endpackage

// File: rtl/iod_read_training_tap_ctrl_if.sv
// Lane-facing and sequencer-facing signals of one read-training IOD lane.
interface iod_read_training_tap_ctrl_if
  import iod_training_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEFAULT
) ();

  logic             START;
  logic [7:0]       RX_DATA_0;
  logic             EYE_MONITOR_EARLY_0;
  logic             EYE_MONITOR_LATE_0;
  logic             DELAY_LINE_OUT_OF_RANGE_0;
  logic             DELAY_LINE_LOAD_0;
  logic             DELAY_LINE_MOVE_0;
  logic             DELAY_LINE_DIRECTION_0;
  logic             EYE_MONITOR_CLEAR_FLAGS_0;
  logic             BUSY;
  logic             DONE;
  logic             FAIL;
  logic [TAP_W-1:0] TAP;
  logic [TAP_W-1:0] EYE_LEFT;
  logic [TAP_W-1:0] EYE_RIGHT;

  modport master (
    input  START, RX_DATA_0, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0,
           DELAY_LINE_OUT_OF_RANGE_0,
    output DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
           EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, TAP, EYE_LEFT, EYE_RIGHT
  );

  modport slave (
    output START, RX_DATA_0, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0,
           DELAY_LINE_OUT_OF_RANGE_0,
    input  DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
           EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, TAP, EYE_LEFT, EYE_RIGHT
  );

endinterface

// File: rtl/iod_read_training_tap_ctrl_settle_timer.sv
// Loadable down-counter; done strobes in the Nth cycle after a load of N.
module training_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/iod_read_training_tap_ctrl.sv
// Read-training tap controller: sweeps the delay line, finds the first
// contiguous passing window and parks the tap at its centre.
module iod_read_training_tap_ctrl
  import iod_training_pkg::*;
#(
  parameter int         TAP_W         = TAP_W_DEFAULT,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         SAMPLES       = 4,
  parameter logic [7:0] EXP_PATTERN   = 8'h55,
  parameter int         MIN_EYE       = 4
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  iod_read_training_tap_ctrl_if.master lane
);

  localparam int               CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int               CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  tap_state_t       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] left_q, left_d;
  logic [TAP_W-1:0] right_q, right_d;
  logic [TAP_W-1:0] target_q, target_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             dir_q, dir_d;
  logic             win_open_q, win_open_d;
  logic             words_ok_q, words_ok_d;
  logic             pass_q, pass_d;
  logic             oor_q, oor_d;
  logic             phase_q, phase_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;
  logic             word_ok;
  logic             sweep_end;
  logic [TAP_W:0]   width;
  logic [TAP_W:0]   mid_sum;

  training_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign word_ok = (lane.RX_DATA_0 == EXP_PATTERN);

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    left_d     = left_q;
    right_d    = right_q;
    target_d   = target_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    dir_d      = dir_q;
    win_open_d = win_open_q;
    words_ok_d = words_ok_q;
    pass_d     = pass_q;
    oor_d      = oor_q;
    phase_d    = phase_q;
    timer_load = 1'b0;
    timer_val  = CNT_W'(SETTLE_CYCLES);
    sweep_end  = 1'b0;
    width      = '0;
    mid_sum    = '0;

    case (state_q)
      IDLE: begin
        if (lane.START) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          left_d  = '0;
          right_d = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tap_d      = '0;
        dir_d      = DIR_INC;
        win_open_d = 1'b0;
        state_d    = CLEAR;
      end
      CLEAR: begin
        timer_load = 1'b1;
        timer_val  = CNT_W'(SETTLE_CYCLES);
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(SAMPLES);
          words_ok_d = 1'b1;
          state_d    = SAMPLE;
        end
      end
      // Flags are sticky, so only their state at the final sample matters.
      SAMPLE: begin
        words_ok_d = words_ok_q & word_ok;
        if (timer_done) begin
          pass_d  = words_ok_q & word_ok & ~lane.EYE_MONITOR_EARLY_0
                    & ~lane.EYE_MONITOR_LATE_0 & ~lane.DELAY_LINE_OUT_OF_RANGE_0;
          oor_d   = lane.DELAY_LINE_OUT_OF_RANGE_0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (pass_q) begin
          if (!win_open_q) begin
            left_d     = tap_q;
            win_open_d = 1'b1;
          end
          right_d = tap_q;
        end
        sweep_end = (win_open_q && !pass_q) || (tap_q == TAP_MAX) || oor_q;
        width     = {1'b0, right_d} - {1'b0, left_d} + 1'b1;
        mid_sum   = {1'b0, left_d} + {1'b0, right_d};
        if (!sweep_end) begin
          state_d = STEP;
        end else if (!win_open_d || (width < (TAP_W+1)'(MIN_EYE))) begin
          state_d = FIN_FAIL;
        end else begin
          target_d = TAP_W'(mid_sum >> 1);
          dir_d    = DIR_DEC;
          phase_d  = 1'b0;
          state_d  = CENTER;
        end
      end
      STEP: begin
        tap_d   = tap_q + 1'b1;
        state_d = CLEAR;
      end
      // Moves alternate with idle cycles so MOVE is never high back-to-back.
      CENTER: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (tap_q != target_q) begin
          tap_d   = tap_q - 1'b1;
          phase_d = 1'b1;
        end else begin
          state_d = FIN_OK;
        end
      end
      FIN_OK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      FIN_FAIL: begin
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      dir_q      <= 1'b0;
      win_open_q <= 1'b0;
      words_ok_q <= 1'b0;
      pass_q     <= 1'b0;
      oor_q      <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      left_q     <= left_d;
      right_q    <= right_d;
      target_q   <= target_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      dir_q      <= dir_d;
      win_open_q <= win_open_d;
      words_ok_q <= words_ok_d;
      pass_q     <= pass_d;
      oor_q      <= oor_d;
      phase_q    <= phase_d;
    end
  end

  assign lane.DELAY_LINE_LOAD_0         = (state_q == LOAD);
  assign lane.DELAY_LINE_MOVE_0         = (state_q == STEP) ||
                                          ((state_q == CENTER) && !phase_q && (tap_q != target_q));
  assign lane.DELAY_LINE_DIRECTION_0    = dir_q;
  assign lane.EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == CLEAR) ||
                                          ((state_q == CENTER) && !phase_q && (tap_q == target_q));
  assign lane.BUSY                      = busy_q;
  assign lane.DONE                      = done_q;
  assign lane.FAIL                      = fail_q;
  assign lane.TAP                       = tap_q;
  assign lane.EYE_LEFT                  = left_q;
  assign lane.EYE_RIGHT                 = right_q;

endmodule

// File: tb/tb_iod_read_training_tap_ctrl.sv
// Bench for the read-training tap controller: a delay-line model with a
// configurable passing window, plus a scoreboard of predicted training results.
module tb_iod_read_training_tap_ctrl;

  localparam int TAP_W = 7;

  typedef struct {
    int done;
    int fail;
    int tap;
    int left;
    int right;
    int up;
    int down;
    int loads;
  } expect_t;

  logic clk = 1'b0;
  logic rstN;

  int winLo   = 200;
  int winHi   = -1;
  int lateTap = -1;
  int oorTap  = -1;

  int   modelTap     = 0;
  int   moveUp       = 0;
  int   moveDown     = 0;
  int   loadCount    = 0;
  int   b2bViolations = 0;
  logic prevAct      = 1'b0;

  int baseUp;
  int baseDown;
  int baseLoads;

  int testsRun    = 0;
  int testsFailed = 0;

  expect_t sbQueue[$];

  always #5 clk = ~clk;

  iod_read_training_tap_ctrl_if #(.TAP_W(TAP_W)) bus ();

  iod_read_training_tap_ctrl #(
    .TAP_W         (TAP_W),
    .SETTLE_CYCLES (8),
    .SAMPLES       (4),
    .EXP_PATTERN   (8'h55),
    .MIN_EYE       (4)
  ) dut (
    .FAB_CLK (clk),
    .ARST_N  (rstN),
    .lane    (bus)
  );

  // Delay-line model: data is correct only inside the configured window.
  assign bus.RX_DATA_0                 = (modelTap >= winLo && modelTap <= winHi) ? 8'h55 : 8'hAA;
  assign bus.EYE_MONITOR_EARLY_0       = 1'b0;
  assign bus.EYE_MONITOR_LATE_0        = (modelTap == lateTap);
  assign bus.DELAY_LINE_OUT_OF_RANGE_0 = (modelTap == oorTap);

  always @(negedge clk) begin
    if (bus.DELAY_LINE_LOAD_0) begin
      loadCount++;
      modelTap = 0;
    end
    if (bus.DELAY_LINE_MOVE_0) begin
      if (bus.DELAY_LINE_DIRECTION_0) begin
        moveUp++;
        if (modelTap < 127) modelTap++;
      end else begin
        moveDown++;
        if (modelTap > 0) modelTap--;
      end
    end
    if ((bus.DELAY_LINE_LOAD_0 && bus.DELAY_LINE_MOVE_0) ||
        ((bus.DELAY_LINE_LOAD_0 || bus.DELAY_LINE_MOVE_0) && prevAct)) begin
      b2bViolations++;
    end
    prevAct = bus.DELAY_LINE_LOAD_0 || bus.DELAY_LINE_MOVE_0;
  end

  // Reference sweep: walk taps upward until the first window closes or the sweep ends.
  function automatic expect_t predict(input int lo, input int hi, input int late, input int oor);
    expect_t e;
    bit      open;
    bit      pass;
    int      l;
    int      r;
    int      t;
    open = 1'b0;
    l = 0;
    r = 0;
    t = 0;
    for (int k = 0; k < 128; k++) begin
      t    = k;
      pass = (k >= lo) && (k <= hi) && (k != late) && (k != oor);
      if (pass) begin
        if (!open) begin
          l    = k;
          open = 1'b1;
        end
        r = k;
      end
      if ((open && !pass) || (k == 127) || (k == oor)) break;
    end
    if (open && (r - l + 1) >= 4) begin
      e.done = 1;
      e.fail = 0;
      e.tap  = (l + r) / 2;
      e.down = t - (l + r) / 2;
    end else begin
      e.done = 0;
      e.fail = 1;
      e.tap  = t;
      e.down = 0;
    end
    e.left  = l;
    e.right = r;
    e.up    = t;
    e.loads = 1;
    return e;
  endfunction

  function automatic logic [31:0] allOutputs();
    return {4'b0, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0,
            bus.EYE_MONITOR_CLEAR_FLAGS_0, bus.BUSY, bus.DONE, bus.FAIL,
            bus.TAP, bus.EYE_LEFT, bus.EYE_RIGHT};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pulseStart();
    bus.START = 1'b1;
    @(negedge clk); #1;
    bus.START = 1'b0;
  endtask

  task automatic applyStimulus(input int lo, input int hi, input int late, input int oor);
    winLo   = lo;
    winHi   = hi;
    lateTap = late;
    oorTap  = oor;
    sbQueue.push_back(predict(lo, hi, late, oor));
    baseUp    = moveUp;
    baseDown  = moveDown;
    baseLoads = loadCount;
    pulseStart();
  endtask

  task automatic waitIdle(input string tag);
    int cycles;
    cycles = 0;
    while (bus.BUSY && cycles < 5000) begin
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput({tag, ".finished"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic compareResult(input string tag);
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, ".scoreboardEmpty"}, 32'd1, 32'd0);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput({tag, ".done"},     32'(bus.DONE),         32'(e.done));
    checkOutput({tag, ".fail"},     32'(bus.FAIL),         32'(e.fail));
    checkOutput({tag, ".tap"},      32'(bus.TAP),          32'(e.tap));
    checkOutput({tag, ".eyeLeft"},  32'(bus.EYE_LEFT),     32'(e.left));
    checkOutput({tag, ".eyeRight"}, 32'(bus.EYE_RIGHT),    32'(e.right));
    checkOutput({tag, ".movesUp"},  32'(moveUp - baseUp),     32'(e.up));
    checkOutput({tag, ".movesDown"},32'(moveDown - baseDown), 32'(e.down));
    checkOutput({tag, ".loads"},    32'(loadCount - baseLoads), 32'(e.loads));
  endtask

  task automatic runCase(input string tag, input int lo, input int hi, input int late, input int oor);
    applyStimulus(lo, hi, late, oor);
    checkOutput({tag, ".busy"}, 32'(bus.BUSY), 32'd1);
    waitIdle(tag);
    compareResult(tag);
  endtask

  initial begin
    int cycles;
    bus.START = 1'b0;
    rstN      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetOutputs", allOutputs(), 32'd0);
    rstN = 1'b1;
    @(negedge clk); #1;

    runCase("window20to40", 20, 40, -1, -1);
    runCase("neverCorrect", 200, -1, -1, -1);
    runCase("narrowWindow", 10, 12, -1, -1);
    runCase("lateAt25",     20, 40, 25, -1);
    runCase("oorAt60",      50, 70, -1, 60);

    // Abort a sweep with reset once the tap has reached 15.
    winLo   = 20;
    winHi   = 40;
    lateTap = -1;
    oorTap  = -1;
    pulseStart();
    cycles = 0;
    while (bus.TAP != TAP_W'(15) && cycles < 2000) begin
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput("reachTap15", 32'(bus.TAP), 32'd15);
    rstN = 1'b0;
    #1;
    checkOutput("midSweepReset", allOutputs(), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk); #1;

    // Fresh start reloads tap 0; a second START while busy must be ignored.
    applyStimulus(20, 40, -1, -1);
    checkOutput("restartLoad", 32'(loadCount - baseLoads), 32'd1);
    @(negedge clk); #1;
    checkOutput("restartTap", 32'(bus.TAP), 32'd0);
    checkOutput("restartModelTap", 32'(modelTap), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    pulseStart();
    checkOutput("busyAfterSecondStart", 32'(bus.BUSY), 32'd1);
    waitIdle("restart");
    compareResult("restart");

    checkOutput("moveLoadSpacing", 32'(b2bViolations), 32'd0);
    checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
